// File: rtl/uart_alu_host.sv
// Initiator for the UART ALU protocol: sends A, B and OP through a UART transmitter,
// then waits for a single result byte, or gives up after a bounded wait.
module uart_alu_host #(
  parameter int N_DATA         = 8,
  parameter int NB_OPERATION   = 6,
  parameter int NB_TIMEOUT     = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_req,
  input  logic [N_DATA-1:0]       i_data_a,
  input  logic [N_DATA-1:0]       i_data_b,
  input  logic [NB_OPERATION-1:0] i_data_op,
  output logic                    o_busy,
  output logic [N_DATA-1:0]       o_result,
  output logic                    o_result_valid,
  output logic                    o_timeout,
  output logic [N_DATA-1:0]       o_tx_data,
  output logic                    o_tx_start,
  input  logic                    i_tx_done,
  input  logic [N_DATA-1:0]       i_rx_data,
  input  logic                    i_rx_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_A,
    S_WAIT_A,
    S_SEND_B,
    S_WAIT_B,
    S_SEND_OP,
    S_WAIT_OP,
    S_WAIT_RES
  } state_t;

  localparam logic [NB_TIMEOUT-1:0] TO_LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [N_DATA-1:0]       a_q, a_d;
  logic [N_DATA-1:0]       b_q, b_d;
  logic [NB_OPERATION-1:0] op_q, op_d;
  logic [NB_TIMEOUT-1:0]   cnt_q, cnt_d;
  logic [N_DATA-1:0]       result_q, result_d;
  logic                    result_valid_q, result_valid_d;
  logic                    timeout_q, timeout_d;
  logic [N_DATA-1:0]       tx_data_q, tx_data_d;
  logic                    tx_start_q, tx_start_d;
  logic                    busy_q;

  // Next-state and next-output logic; pulses default low, everything else holds.
  always_comb begin
    state_d        = state_q;
    a_d            = a_q;
    b_d            = b_q;
    op_d           = op_q;
    cnt_d          = cnt_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    timeout_d      = 1'b0;
    tx_data_d      = tx_data_q;
    tx_start_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_req) begin
          a_d     = i_data_a;
          b_d     = i_data_b;
          op_d    = i_data_op;
          state_d = S_SEND_A;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND_A: begin
        tx_data_d  = a_q;
        tx_start_d = 1'b1;
        state_d    = S_WAIT_A;
      end
      S_WAIT_A: begin
        if (i_tx_done) state_d = S_SEND_B;
        else           state_d = S_WAIT_A;
      end
      S_SEND_B: begin
        tx_data_d  = b_q;
        tx_start_d = 1'b1;
        state_d    = S_WAIT_B;
      end
      S_WAIT_B: begin
        if (i_tx_done) state_d = S_SEND_OP;
        else           state_d = S_WAIT_B;
      end
      S_SEND_OP: begin
        tx_data_d  = N_DATA'(op_q);
        tx_start_d = 1'b1;
        state_d    = S_WAIT_OP;
      end
      S_WAIT_OP: begin
        if (i_tx_done) begin
          cnt_d   = '0;
          state_d = S_WAIT_RES;
        end else begin
          state_d = S_WAIT_OP;
        end
      end
      S_WAIT_RES: begin
        // A result arriving on the expiry cycle takes priority over the timeout.
        if (i_rx_done) begin
          result_d       = i_rx_data;
          result_valid_d = 1'b1;
          state_d        = S_IDLE;
        end else if (cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + NB_TIMEOUT'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q        <= S_IDLE;
      a_q            <= '0;
      b_q            <= '0;
      op_q           <= '0;
      cnt_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      tx_data_q      <= '0;
      tx_start_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      a_q            <= a_d;
      b_q            <= b_d;
      op_q           <= op_d;
      cnt_q          <= cnt_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      timeout_q      <= timeout_d;
      tx_data_q      <= tx_data_d;
      tx_start_q     <= tx_start_d;
      busy_q         <= (state_d != S_IDLE);
    end
  end

  assign o_busy         = busy_q;
  assign o_result       = result_q;
  assign o_result_valid = result_valid_q;
  assign o_timeout      = timeout_q;
  assign o_tx_data      = tx_data_q;
  assign o_tx_start     = tx_start_q;

endmodule

// File: tb/tb_uart_alu_host.sv
// Self-checking bench for uart_alu_host: table of transactions plus randomized ones,
// with a transaction-level reference model, and hand sequences for reset and back-to-back.
module tb_uart_alu_host;

  localparam int T = 10;
  localparam int NO_RX = 99;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_req;
  logic [7:0] i_data_a, i_data_b;
  logic [5:0] i_data_op;
  logic       o_busy;
  logic [7:0] o_result;
  logic       o_result_valid, o_timeout;
  logic [7:0] o_tx_data;
  logic       o_tx_start;
  logic       i_tx_done;
  logic [7:0] i_rx_data;
  logic       i_rx_done;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_result = 8'h00;

  uart_alu_host #(
    .N_DATA(8), .NB_OPERATION(6), .NB_TIMEOUT(16), .TIMEOUT_CYCLES(T)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req),
    .i_data_a(i_data_a), .i_data_b(i_data_b), .i_data_op(i_data_op),
    .o_busy(o_busy), .o_result(o_result), .o_result_valid(o_result_valid),
    .o_timeout(o_timeout), .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
    .i_tx_done(i_tx_done), .i_rx_data(i_rx_data), .i_rx_done(i_rx_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    int         k;      // cycles after WAIT_RES entry before the result byte (NO_RX = never)
    logic [7:0] rx;
    bit         noise;  // random junk on i_req / i_rx_done / operands while sending
    bit         b2b;    // next request issued in the o_result_valid cycle
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change just after a falling edge; outputs are observed at the next falling edge.
  task automatic cyc();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic junk(input bit en);
    if (en) begin
      i_req     = 1'($urandom_range(0, 1));
      i_rx_done = 1'($urandom_range(0, 1));
      i_rx_data = 8'($urandom);
      i_data_a  = 8'($urandom);
      i_data_b  = 8'($urandom);
      i_data_op = 6'($urandom);
    end else begin
      i_req     = 1'b0;
      i_rx_done = 1'b0;
    end
  endtask

  task automatic run_txn(input vec_t v);
    logic [7:0] bytes [3];
    int n, d, last;
    bit got;
    bytes[0] = v.a;
    bytes[1] = v.b;
    bytes[2] = {2'b00, v.op};
    i_data_a = v.a; i_data_b = v.b; i_data_op = v.op; i_req = 1'b1;
    cyc();
    chk("busy_after_req", o_busy, 1);
    for (int j = 0; j < 3; j++) begin
      n = 0;
      while (!o_tx_start && n < 4) begin
        junk(v.noise);
        cyc();
        n++;
      end
      chk("tx_start_seen", o_tx_start, 1);
      chk("tx_byte", o_tx_data, bytes[j]);
      chk("no_pulse_while_tx", {o_result_valid, o_timeout}, 0);
      if (j > 0) chk("tx_done_to_start", n, 1);
      d = $urandom_range(0, 2);
      for (int h = 0; h < d; h++) begin
        junk(v.noise);
        cyc();
        chk("tx_start_one_cycle", o_tx_start, 0);
        chk("tx_data_held", o_tx_data, bytes[j]);
      end
      junk(v.noise);
      i_tx_done = 1'b1;
      cyc();
      i_tx_done = 1'b0;
      chk("busy_while_tx", o_busy, 1);
    end
    // Now in the first cycle of the response wait.
    junk(1'b0);
    i_rx_data = v.rx;
    last = (v.k < T) ? v.k : T - 1;
    for (int c = 0; c <= T + 1; c++) begin
      i_rx_done = (c == v.k);
      cyc();
      i_rx_done = 1'b0;
      got = (c == v.k) && (v.k < T);
      if (got) exp_result = v.rx;
      chk("result_valid", o_result_valid, got);
      chk("timeout", o_timeout, (c == T - 1) && (v.k >= T));
      chk("result", o_result, exp_result);
      chk("busy_resp", o_busy, c < last);
      chk("no_tx_start_resp", o_tx_start, 0);
      if (got && v.b2b) break;
    end
  endtask

  vec_t vecs [6];
  vec_t rv;

  initial begin
    vecs[0] = '{8'h12, 8'h34, 6'b100000, 2,     8'h46, 1'b0, 1'b0};
    vecs[1] = '{8'hAA, 8'h55, 6'h3F,     NO_RX, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{8'h01, 8'h02, 6'h01,     T - 1, 8'hC3, 1'b0, 1'b0};
    vecs[3] = '{8'h77, 8'h88, 6'h05,     0,     8'h5A, 1'b1, 1'b0};
    vecs[4] = '{8'hF0, 8'h0F, 6'h2A,     1,     8'h11, 1'b0, 1'b1};
    vecs[5] = '{8'h0E, 8'hE0, 6'h15,     3,     8'h22, 1'b0, 1'b0};

    i_rst = 1'b0; i_req = 1'b0; i_tx_done = 1'b0; i_rx_done = 1'b0;
    i_data_a = 8'h00; i_data_b = 8'h00; i_data_op = 6'h00; i_rx_data = 8'h00;
    @(negedge i_clk);
    cyc();
    cyc();
    chk("reset_outputs", {o_busy, o_result, o_result_valid, o_timeout, o_tx_data, o_tx_start}, 0);
    i_rst = 1'b1;
    i_rx_done = 1'b1; i_rx_data = 8'hFF;
    cyc();
    i_rx_done = 1'b0;
    chk("rx_in_idle_dropped", {o_busy, o_result, o_result_valid}, 0);

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Reset while waiting for the B byte to finish, then a late tx_done.
    i_data_a = 8'h3C; i_data_b = 8'hC3; i_data_op = 6'h07; i_req = 1'b1;
    cyc();
    i_req = 1'b0;
    cyc();
    chk("rst_seq_a", o_tx_data, 8'h3C);
    i_tx_done = 1'b1;
    cyc();
    i_tx_done = 1'b0;
    cyc();
    chk("rst_seq_b", {o_tx_start, o_tx_data}, {1'b1, 8'hC3});
    i_rst = 1'b0;
    cyc();
    i_rst = 1'b1;
    exp_result = 8'h00;
    chk("mid_reset_outputs", {o_busy, o_result, o_result_valid, o_timeout, o_tx_data, o_tx_start}, 0);
    i_tx_done = 1'b1;
    cyc();
    i_tx_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_tx_done_ignored", {o_busy, o_tx_start, o_tx_data}, 0);
      cyc();
    end
    rv = '{8'h5A, 8'hA5, 6'h11, 4, 8'h99, 1'b0, 1'b0};
    run_txn(rv);

    for (int i = 0; i < 20; i++) begin
      rv.a = 8'($urandom); rv.b = 8'($urandom); rv.op = 6'($urandom);
      rv.k = ($urandom_range(0, 5) == 0) ? NO_RX : int'($urandom_range(0, T + 1));
      rv.rx = 8'($urandom);
      rv.noise = 1'($urandom_range(0, 1));
      rv.b2b = 1'($urandom_range(0, 1));
      run_txn(rv);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
